// File: rtl/serial_pair_serializer_pkg.sv
// Shared types and helpers for the two-operand serial bit-stream transmitter.
// The counter width never drops below one bit, so WIDTH=1 still has a legal counter.
package serial_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic int cnt_w(input int width);
        return ($clog2(width) > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_pair_serializer_if.sv
// Parallel word-pair input handshake plus the serial a/b stream with word framing.
// Master offers words and consumes the stream; slave is the serializer.
interface serial_pair_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_first;
    logic             out_last;
    logic             a;
    logic             b;

    modport master (
        output in_valid, in_a, in_b,
        input  in_ready, out_valid, out_first, out_last, a, b
    );

    modport slave (
        input  in_valid, in_a, in_b,
        output in_ready, out_valid, out_first, out_last, a, b
    );
endinterface

// File: rtl/serial_pair_serializer_shift_reg.sv
// Loadable shift register emitting one bit per shift, MSB- or LSB-first.
// Load has priority over shift; serial output is the bit about to leave.
module serial_shift_reg #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             dout
);
    logic [WIDTH-1:0] r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r <= '0;
        end else if (load) begin
            r <= din;
        end else if (shift) begin
            r <= MSB_FIRST ? (r << 1) : (r >> 1);
        end
    end

    assign dout = MSB_FIRST ? r[WIDTH-1] : r[0];

endmodule

// File: rtl/serial_pair_serializer.sv
// Serializes accepted (in_a, in_b) pairs one bit per clock with first/last framing.
// First bit appears the cycle after accept; ready only when idle or on a word's last bit.
module serial_pair_serializer
    import serial_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    serial_pair_if.slave bus
);
    localparam int            CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          rdy_en;
    logic          load, shift, accept, at_last;
    logic          a_bit, b_bit;

    // rdy_en holds ready low on the reset-release edge so nothing is accepted there
    assign at_last      = (state == SHIFT) && (cnt == LAST);
    assign bus.in_ready = rdy_en && ((state == IDLE) || at_last);
    assign accept       = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            rdy_en <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            rdy_en <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load      = 1'b0;
        shift     = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    load      = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (at_last) begin
                    if (accept) begin
                        load    = 1'b1;
                        cnt_nxt = '0;
                    end else begin
                        shift     = 1'b1;
                        state_nxt = IDLE;
                    end
                end else begin
                    shift   = 1'b1;
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    serial_shift_reg #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_sr_a (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .shift (shift),
        .din   (bus.in_a),
        .dout  (a_bit)
    );

    serial_shift_reg #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_sr_b (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .shift (shift),
        .din   (bus.in_b),
        .dout  (b_bit)
    );

    assign bus.out_valid = (state == SHIFT);
    assign bus.out_first = bus.out_valid && (cnt == '0);
    assign bus.out_last  = at_last;
    assign bus.a         = bus.out_valid && a_bit;
    assign bus.b         = bus.out_valid && b_bit;

endmodule

// File: tb/tb_serial_pair_serializer.sv
// Bench for serial_pair_serializer: MSB-first and LSB-first WIDTH=8 builds plus a WIDTH=1 build.
module tb_serial_pair_serializer;

    typedef struct packed {
        logic a;
        logic b;
        logic first;
        logic last;
    } bit_t;

    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit_t exp_q[$];
    bit_t exp_l[$];

    serial_pair_if #(.WIDTH(8)) bus   ();
    serial_pair_if #(.WIDTH(8)) bus_l ();
    serial_pair_if #(.WIDTH(1)) bus1  ();

    serial_pair_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut   (.clk(clk), .rst(rst), .bus(bus));
    serial_pair_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst(rst), .bus(bus_l));
    serial_pair_serializer #(.WIDTH(1), .MSB_FIRST(1'b1)) dut1  (.clk(clk), .rst(rst), .bus(bus1));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic drive(input logic v, input logic [7:0] wa, input logic [7:0] wb);
        bus.in_valid   = v;
        bus.in_a       = wa;
        bus.in_b       = wb;
        bus_l.in_valid = v;
        bus_l.in_a     = wa;
        bus_l.in_b     = wb;
    endtask

    function automatic void push_word(input logic [7:0] wa, input logic [7:0] wb);
        bit_t e;
        for (int i = 0; i < 8; i++) begin
            e.a = wa[7-i]; e.b = wb[7-i]; e.first = (i == 0); e.last = (i == 7);
            exp_q.push_back(e);
            e.a = wa[i];   e.b = wb[i];
            exp_l.push_back(e);
        end
    endfunction

    // Scoreboard: every valid output bit must match the next expected bit in order
    always @(negedge clk) begin
        bit_t got, e;
        got = {bus.a, bus.b, bus.out_first, bus.out_last};
        n_cmp++;
        if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL stream_msb: unexpected valid bit got=%b required no valid bit", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    n_bad++;
                    $display("FAIL stream_msb: got {a,b,first,last}=%b required %b", got, e);
                end
            end
        end else if (got !== 4'b0000) begin
            n_bad++;
            $display("FAIL idle_msb: got {a,b,first,last}=%b required 0000", got);
        end
        got = {bus_l.a, bus_l.b, bus_l.out_first, bus_l.out_last};
        n_cmp++;
        if (bus_l.out_valid) begin
            if (exp_l.size() == 0) begin
                n_bad++;
                $display("FAIL stream_lsb: unexpected valid bit got=%b required no valid bit", got);
            end else begin
                e = exp_l.pop_front();
                if (got !== e) begin
                    n_bad++;
                    $display("FAIL stream_lsb: got {a,b,first,last}=%b required %b", got, e);
                end
            end
        end else if (got !== 4'b0000) begin
            n_bad++;
            $display("FAIL idle_lsb: got {a,b,first,last}=%b required 0000", got);
        end
    end

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({bus.in_ready, bus.out_valid, bus_l.in_ready, bus1.in_ready, bus1.out_valid} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_state: got rdy/vld=%b required 00000",
                     {bus.in_ready, bus.out_valid, bus_l.in_ready, bus1.in_ready, bus1.out_valid});
        end
        drive(1'b1, 8'h11, 8'h22);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL release_ready_early: got %b required 0", bus.in_ready);
        end
        @(negedge clk);
        n_cmp++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            n_bad++;
            $display("FAIL release_no_accept: got rdy,vld=%b required 10", {bus.in_ready, bus.out_valid});
        end
        drive(1'b0, 8'h00, 8'h00);
    endtask

    task automatic test_single;
        @(negedge clk);
        drive(1'b1, 8'hA5, 8'h3C);
        push_word(8'hA5, 8'h3C);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) drive(1'b0, 8'($urandom), 8'($urandom));
            n_cmp++;
            if (bus.in_ready !== (k == 8)) begin
                n_bad++;
                $display("FAIL single_ready cycle %0d: got %b required %b", k, bus.in_ready, (k == 8));
            end
        end
        @(negedge clk);
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL single_end: out_valid got %b required 0", bus.out_valid);
        end
    endtask

    task automatic test_back_to_back;
        int vcnt = 0;
        @(negedge clk);
        drive(1'b1, 8'h5A, 8'h96);
        push_word(8'h5A, 8'h96);
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            if (bus.out_valid) vcnt++;
            if (k == 1) drive(1'b0, 8'($urandom), 8'($urandom));
            if (k == 8) begin
                n_cmp++;
                if (bus.in_ready !== 1'b1) begin
                    n_bad++;
                    $display("FAIL b2b_ready: got %b required 1", bus.in_ready);
                end
                drive(1'b1, 8'hFF, 8'h00);
                push_word(8'hFF, 8'h00);
            end
            if (k == 9) begin
                drive(1'b0, 8'($urandom), 8'($urandom));
                n_cmp++;
                if ({bus.out_valid, bus.out_first, bus.a, bus.b} !== 4'b1110) begin
                    n_bad++;
                    $display("FAIL b2b_second_first: got vld,first,a,b=%b required 1110",
                             {bus.out_valid, bus.out_first, bus.a, bus.b});
                end
            end
        end
        n_cmp++;
        if (vcnt != 16 || bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_valid_run: got %0d valid cycles (vld now %b) required 16 (vld now 0)",
                     vcnt, bus.out_valid);
        end
    endtask

    task automatic test_holdoff;
        logic [7:0] ra, rb;
        @(negedge clk);
        drive(1'b1, 8'hC3, 8'h69);
        push_word(8'hC3, 8'h69);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            ra = 8'($urandom);
            rb = 8'($urandom);
            drive(k >= 2, ra, rb);
            if (k >= 2) begin
                n_cmp++;
                if (bus.in_ready !== (k == 8)) begin
                    n_bad++;
                    $display("FAIL holdoff_ready cycle %0d: got %b required %b", k, bus.in_ready, (k == 8));
                end
            end
            if (k == 8) push_word(ra, rb);
        end
        @(negedge clk);
        drive(1'b0, 8'($urandom), 8'($urandom));
        repeat (8) @(negedge clk);
    endtask

    task automatic test_width1;
        logic pa, pb, na, nb;
        @(negedge clk);
        pa = 1'b1; pb = 1'b0;
        bus1.in_valid = 1'b1; bus1.in_a = pa; bus1.in_b = pb;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({bus1.out_valid, bus1.out_first, bus1.out_last, bus1.a, bus1.b, bus1.in_ready} !==
                {3'b111, pa, pb, 1'b1}) begin
                n_bad++;
                $display("FAIL width1 cycle %0d: got vld,first,last,a,b,rdy=%b required %b", k,
                         {bus1.out_valid, bus1.out_first, bus1.out_last, bus1.a, bus1.b, bus1.in_ready},
                         {3'b111, pa, pb, 1'b1});
            end
            na = 1'($urandom); nb = 1'($urandom);
            bus1.in_valid = (k < 3); bus1.in_a = na; bus1.in_b = nb;
            pa = na; pb = nb;
        end
        @(negedge clk);
        n_cmp++;
        if ({bus1.out_valid, bus1.a, bus1.b, bus1.out_first, bus1.out_last} !== 5'b0) begin
            n_bad++;
            $display("FAIL width1_idle: got %b required 00000",
                     {bus1.out_valid, bus1.a, bus1.b, bus1.out_first, bus1.out_last});
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        drive(1'b1, 8'hE7, 8'h18);
        push_word(8'hE7, 8'h18);
        @(negedge clk);
        drive(1'b0, 8'h00, 8'h00);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({bus.out_valid, bus.in_ready, bus_l.out_valid, bus_l.in_ready} !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_mid_abort: got vld,rdy,vld_l,rdy_l=%b required 0000",
                     {bus.out_valid, bus.in_ready, bus_l.out_valid, bus_l.in_ready});
        end
        exp_q.delete();
        exp_l.delete();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            n_bad++;
            $display("FAIL reset_mid_release: got rdy,vld=%b required 10", {bus.in_ready, bus.out_valid});
        end
        drive(1'b1, 8'h81, 8'h42);
        push_word(8'h81, 8'h42);
        @(negedge clk);
        drive(1'b0, 8'h00, 8'h00);
        n_cmp++;
        if (bus.out_first !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid_restart: out_first got %b required 1", bus.out_first);
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_drained;
        @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0 || exp_l.size() != 0) begin
            n_bad++;
            $display("FAIL drained: got %0d/%0d pending bits required 0/0", exp_q.size(), exp_l.size());
        end
    endtask

    initial begin
        rst           = 1'b0;
        drive(1'b0, 8'h00, 8'h00);
        bus1.in_valid = 1'b0;
        bus1.in_a     = 1'b0;
        bus1.in_b     = 1'b0;
        test_reset;
        test_single;
        test_back_to_back;
        test_holdoff;
        test_width1;
        test_reset_mid;
        test_drained;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
